// File: rtl/rw_cas_scheduler_if.sv
// rw_cas_scheduler_if: read/write CAS request pushes, the CAS command
// handshake towards the burst engine and queue occupancy status.
// slave = scheduler side, master = client / burst-engine side.
interface rw_cas_scheduler_if #(
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [1:0]    rd_req_bg;
  logic [1:0]    rd_req_ba;
  logic [9:0]    rd_req_col;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [1:0]    wr_req_bg;
  logic [1:0]    wr_req_ba;
  logic [9:0]    wr_req_col;
  logic          cas_valid;
  logic          cas_ready;
  logic          cas_rw;
  logic [1:0]    cas_bg;
  logic [1:0]    cas_ba;
  logic [9:0]    cas_col;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;
  logic          sched_idle;

  modport slave (
    input  rd_req_valid, rd_req_bg, rd_req_ba, rd_req_col,
    input  wr_req_valid, wr_req_bg, wr_req_ba, wr_req_col,
    input  cas_ready,
    output rd_req_ready, wr_req_ready,
    output cas_valid, cas_rw, cas_bg, cas_ba, cas_col,
    output rd_count, wr_count, sched_idle
  );

  modport master (
    output rd_req_valid, rd_req_bg, rd_req_ba, rd_req_col,
    output wr_req_valid, wr_req_bg, wr_req_ba, wr_req_col,
    output cas_ready,
    input  rd_req_ready, wr_req_ready,
    input  cas_valid, cas_rw, cas_bg, cas_ba, cas_col,
    input  rd_count, wr_count, sched_idle
  );
endinterface

// File: rtl/rw_cas_scheduler.sv
// rw_cas_scheduler: read/write CAS queues, direction choice by write
// watermarks and read streak, CAS-to-CAS spacing, one command out.
// Ports: clock_t, reset (sync, active-high), bus (slave modport).
module rw_cas_scheduler #(
  parameter int QDEPTH        = 4,
  parameter int CL            = 11,
  parameter int CWL           = 9,
  parameter int BL            = 8,
  parameter int TCCD_S        = 4,
  parameter int TCCD_L        = 6,
  parameter int TWTR          = 6,
  parameter int WR_HI_WM      = 3,
  parameter int WR_LO_WM      = 0,
  parameter int MAX_RD_STREAK = 8
) (
  input logic               clock_t,
  input logic               reset,
  rw_cas_scheduler_if.slave bus
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  localparam logic [8:0] G_S   = 9'(TCCD_S);
  localparam logic [8:0] G_L   = 9'(TCCD_L);
  localparam logic [8:0] G_RTW = 9'(CWL + BL / 2 + TWTR);
  localparam logic [8:0] G_WTR = 9'(CL + BL / 2 + 2 - CWL);

  localparam logic [CW-1:0] QD   = CW'(QDEPTH);
  localparam logic [CW-1:0] HI   = CW'(WR_HI_WM);
  localparam logic [CW-1:0] LO   = CW'(WR_LO_WM);
  localparam logic [SW-1:0] SMAX = SW'(MAX_RD_STREAK);

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_RD,
    SCH_WR
  } sch_e;

  typedef struct packed {
    logic [1:0] bg;
    logic [1:0] ba;
    logic [9:0] col;
  } req_t;

  req_t          rd_mem_q [QDEPTH];
  req_t          rd_mem_d [QDEPTH];
  req_t          wr_mem_q [QDEPTH];
  req_t          wr_mem_d [QDEPTH];
  logic [PW-1:0] rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
  logic [PW-1:0] wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  sch_e          state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          last_vld_q, last_vld_d;
  logic          last_rw_q, last_rw_d;
  logic [1:0]    last_bg_q, last_bg_d;
  logic [7:0]    elapsed_q, elapsed_d;
  logic          cas_valid_q, cas_valid_d;
  logic          cas_rw_q, cas_rw_d;
  req_t          cas_q, cas_d;

  logic rd_empty, wr_empty;
  logic rd_push, wr_push, rd_pop, wr_pop;
  logic hs, load;
  req_t head;
  logic [8:0] gap;

  assign rd_empty = (rd_cnt_q == '0);
  assign wr_empty = (wr_cnt_q == '0);
  assign rd_push  = bus.rd_req_valid && (rd_cnt_q != QD);
  assign wr_push  = bus.wr_req_valid && (wr_cnt_q != QD);
  assign hs       = cas_valid_q && bus.cas_ready;

  // Direction for this cycle; also the next registered state.
  always_comb begin
    state_d = SCH_RD;
    if (rd_empty && wr_empty) begin
      state_d = SCH_IDLE;
    end else if (state_q == SCH_WR) begin
      if (!wr_empty && !(wr_cnt_q <= LO && !rd_empty))
        state_d = SCH_WR;
    end else if (wr_cnt_q >= HI || rd_empty ||
                 (streak_q >= SMAX && !wr_empty)) begin
      state_d = SCH_WR;
    end
  end

  // Required spacing from the last accepted command to the candidate.
  always_comb begin
    head = (state_d == SCH_WR) ? wr_mem_q[wr_rp_q]
                               : rd_mem_q[rd_rp_q];
    gap  = '0;
    if (last_vld_q) begin
      if ((state_d == SCH_RD) == last_rw_q)
        gap = (head.bg == last_bg_q) ? G_L : G_S;
      else if (state_d == SCH_RD)
        gap = G_RTW;
      else
        gap = G_WTR;
    end
  end

  // elapsed counts from 1 in the cycle after a handshake, so the
  // handshake of a load at elapsed = gap-1 lands exactly gap later.
  assign load   = !cas_valid_q && (state_d != SCH_IDLE) &&
                  (({1'b0, elapsed_q} + 9'd1) >= gap);
  assign rd_pop = load && (state_d == SCH_RD);
  assign wr_pop = load && (state_d == SCH_WR);

  always_comb begin
    rd_mem_d = rd_mem_q;
    wr_mem_d = wr_mem_q;
    if (rd_push)
      rd_mem_d[rd_wp_q] = '{bus.rd_req_bg, bus.rd_req_ba, bus.rd_req_col};
    if (wr_push)
      wr_mem_d[wr_wp_q] = '{bus.wr_req_bg, bus.wr_req_ba, bus.wr_req_col};
    rd_wp_d  = rd_push ? rd_wp_q + PW'(1) : rd_wp_q;
    wr_wp_d  = wr_push ? wr_wp_q + PW'(1) : wr_wp_q;
    rd_rp_d  = rd_pop ? rd_rp_q + PW'(1) : rd_rp_q;
    wr_rp_d  = wr_pop ? wr_rp_q + PW'(1) : wr_rp_q;
    rd_cnt_d = rd_cnt_q + CW'(rd_push) - CW'(rd_pop);
    wr_cnt_d = wr_cnt_q + CW'(wr_push) - CW'(wr_pop);
  end

  always_comb begin
    streak_d    = streak_q;
    last_vld_d  = last_vld_q;
    last_rw_d   = last_rw_q;
    last_bg_d   = last_bg_q;
    cas_valid_d = cas_valid_q;
    cas_rw_d    = cas_rw_q;
    cas_d       = cas_q;
    elapsed_d   = (elapsed_q == 8'hFF) ? elapsed_q : elapsed_q + 8'd1;
    if (hs) begin
      cas_valid_d = 1'b0;
      last_vld_d  = 1'b1;
      last_rw_d   = cas_rw_q;
      last_bg_d   = cas_q.bg;
      elapsed_d   = 8'd1;
      if (!cas_rw_q)
        streak_d = '0;
      else if (streak_q != SMAX)
        streak_d = streak_q + SW'(1);
    end
    if (load) begin
      cas_valid_d = 1'b1;
      cas_rw_d    = (state_d == SCH_RD);
      cas_d       = head;
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      rd_wp_q     <= '0;
      rd_rp_q     <= '0;
      wr_wp_q     <= '0;
      wr_rp_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      state_q     <= SCH_IDLE;
      streak_q    <= '0;
      last_vld_q  <= 1'b0;
      last_rw_q   <= 1'b0;
      last_bg_q   <= '0;
      elapsed_q   <= 8'hFF;
      cas_valid_q <= 1'b0;
      cas_rw_q    <= 1'b0;
      cas_q       <= '0;
    end else begin
      rd_mem_q    <= rd_mem_d;
      wr_mem_q    <= wr_mem_d;
      rd_wp_q     <= rd_wp_d;
      rd_rp_q     <= rd_rp_d;
      wr_wp_q     <= wr_wp_d;
      wr_rp_q     <= wr_rp_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      state_q     <= state_d;
      streak_q    <= streak_d;
      last_vld_q  <= last_vld_d;
      last_rw_q   <= last_rw_d;
      last_bg_q   <= last_bg_d;
      elapsed_q   <= elapsed_d;
      cas_valid_q <= cas_valid_d;
      cas_rw_q    <= cas_rw_d;
      cas_q       <= cas_d;
    end
  end

  assign bus.rd_req_ready = (rd_cnt_q != QD);
  assign bus.wr_req_ready = (wr_cnt_q != QD);
  assign bus.cas_valid    = cas_valid_q;
  assign bus.cas_rw       = cas_rw_q;
  assign bus.cas_bg       = cas_q.bg;
  assign bus.cas_ba       = cas_q.ba;
  assign bus.cas_col      = cas_q.col;
  assign bus.rd_count     = rd_cnt_q;
  assign bus.wr_count     = wr_cnt_q;
  assign bus.sched_idle   = rd_empty && wr_empty && !cas_valid_q;
endmodule

// File: doc/rw_cas_scheduler.md
Name: rw_cas_scheduler

Overview:
Sits between the bank/row logic and the burst read/write timing engine. Holds separate read and write CAS request queues and picks the direction using write watermarks and a read-streak limit. Enforces CAS-to-CAS spacing (tCCD_S/tCCD_L, write-to-read, read-to-write) before presenting one command at a time on a valid/ready interface to the burst engine.

Parameters:
QDEPTH, 4, entries per request queue (power of 2, ≥2)
CL, 11, read CAS latency (cycles)
CWL, 9, write CAS latency (cycles)
BL, 8, burst length (even)
TCCD_S, 4, CAS-to-CAS spacing, different bank group (≥2)
TCCD_L, 6, CAS-to-CAS spacing, same bank group (≥TCCD_S)
TWTR, 6, write-to-read internal delay
WR_HI_WM, 3, write-queue count forcing write mode (1..QDEPTH)
WR_LO_WM, 0, write-queue count at or below which write mode yields to reads
MAX_RD_STREAK, 8, consecutive reads allowed while writes wait

Ports:
clock_t  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
rd_req_valid  in  1  read request offered
rd_req_ready  out  1  read queue not full
rd_req_bg  in  2  read bank group
rd_req_ba  in  2  read bank
rd_req_col  in  10  read column
wr_req_valid/wr_req_ready/wr_req_bg/wr_req_ba/wr_req_col  same as read set, for writes
cas_valid  out  1  CAS command presented
cas_ready  in  1  burst engine accepts
cas_rw  out  1  1=READ, 0=WRITE
cas_bg  out  2
cas_ba  out  2
cas_col  out  10
rd_count  out  $clog2(QDEPTH+1)  read queue occupancy
wr_count  out  $clog2(QDEPTH+1)  write queue occupancy
sched_idle  out  1  both queues empty and cas_valid=0

Behaviour:
- Reset is synchronous and active-high. It flushes both queues. Reset values: rd/wr_count=0, rd/wr_req_ready=1, cas_valid=0, cas_rw/bg/ba/col=0, sched_idle=1, state=SCH_IDLE, rd_streak=0, last_vld=0, elapsed=255. Reset mid-operation discards any held command without handshake.
- Queues: FIFO; push on valid&&ready; req_ready=!full, with no push-through while full. A pushed entry is visible at the head the cycle after the push, so a push into an empty queue cannot pop in the same cycle. Pointers wrap modulo QDEPTH.
- Direction function D, computed combinationally each cycle; the registered state takes the value of D:
  - Both queues empty: D=SCH_IDLE.
  - State SCH_IDLE or SCH_RD: D=SCH_WR if wr_count≥WR_HI_WM, rd empty, or (rd_streak≥MAX_RD_STREAK and wr nonempty). Otherwise D=SCH_RD.
  - State SCH_WR: D=SCH_RD if wr empty, or (wr_count≤WR_LO_WM and rd nonempty). Otherwise D=SCH_WR.
- Spacing g against the last handshaken command (last_rw, last_bg):
  - Same direction: g=TCCD_L if same bg, else TCCD_S.
  - Read after write: g=CWL+BL/2+TWTR (default 19).
  - Write after read: g=CL+BL/2+2−CWL (default 8).
  - last_vld=0: g=0.
- elapsed: 8-bit saturating counter. It is set to 1 in the cycle after a handshake and otherwise increments.
- Load: if cas_valid=0, D≠SCH_IDLE and elapsed≥g−1, pop the head of queue D into the output register. cas_valid rises the next cycle. No load happens in a handshake cycle.
- Handshake (cas_valid&&cas_ready):
  - cas_valid←0; last_rw/last_bg updated; last_vld←1.
  - Read handshake: rd_streak+1, saturating at MAX_RD_STREAK. Write handshake: rd_streak←0.
- Output fields are stable while cas_valid=1 and cas_ready=0. No pop occurs while stalled.
- Latency: push at cycle t into an idle scheduler gives cas_valid at t+2. Handshakes are spaced ≥g cycles apart.
- Simultaneous events:
  - A push and a pop on the same queue in one cycle leave the count unchanged.
  - Read and write pushes in the same cycle are both accepted.
  - Direction ties in SCH_IDLE go to reads unless the write watermark applies.

Test Plan:
- After reset, push read bg=1 ba=2 col=0x010 at cycle 0 with cas_ready=1 -> cas_valid=1 at cycle 2 with rw=1, bg=1, ba=2, col=0x010; sched_idle=0 during cycles 1–2 and 1 at cycle 3.
- Two queued reads, same bg, cas_ready=1 -> handshakes 6 cycles apart. Repeat with different bg -> 4 cycles apart.
- Write then read queued -> handshakes 19 cycles apart. Read then write (write below watermark, read queue empty) -> 8 cycles apart.
- Fill 4 reads, then push 3 writes -> wr_count=3 forces SCH_WR after the current read. All 3 writes issue back-to-back, then reads resume. Separately, a streak of 8 reads with 1 write pending -> the write issues 9th.
- Hold cas_ready=0 for 5 cycles with command presented -> fields stable, rd_count unchanged. Fill the read queue -> rd_req_ready=0 and extra pushes are ignored.
- Assert reset for 1 cycle with 3 reads queued and cas_valid=1 -> next cycle cas_valid=0, counts=0, both readies=1. The next read issues at push+2 with no spacing wait.
